ram_dp_be: RTL and testbench



---
 rtl/ram_pkg.sv | 34 +++
 rtl/ram_clear_seq.sv | 60 ++++++
 rtl/ram_dp_be.sv | 140 ++++++++++++++
 tb/tb_ram_dp_be.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the byte-strobed dual-port RAM: read-during-write modes,
// clear-sequencer states and the byte-lane merge used by both write and bypass paths.
package ram_pkg;

    localparam int RDW_OLD    = 0;
    localparam int RDW_NEW    = 1;
    localparam int RAM_MAX_DW = 256;
    localparam int RAM_IDX_W  = $clog2(RAM_MAX_DW);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ram_state_e;

    // Lanes whose strobe bit is set take new_word, the rest keep old_word.
    function automatic logic [RAM_MAX_DW-1:0] ram_merge(
        input logic [RAM_MAX_DW-1:0] old_word,
        input logic [RAM_MAX_DW-1:0] new_word,
        input logic [RAM_MAX_DW-1:0] strobe,
        input int                    byte_width
    );
        logic [RAM_MAX_DW-1:0] mask;
        logic [RAM_IDX_W-1:0]  bit_idx;
        logic [RAM_IDX_W-1:0]  lane_idx;
        mask = {RAM_MAX_DW{1'b0}};
        for (int b = 0; b < RAM_MAX_DW; b++) begin
            bit_idx       = RAM_IDX_W'(b);
            lane_idx      = RAM_IDX_W'(b / byte_width);
            mask[bit_idx] = strobe[lane_idx];
        end
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// CLEAR/RUN sequencer: walks every word once after reset issuing zero writes,
// then raises ready for the rest of operation.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int SIZE           = 1024,
    parameter int CLEAR_ON_RESET = 1,
    parameter int ADDRESS_WIDTH  = 10
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    output logic                     o_ready,
    output logic                     o_clr_we,
    output logic [ADDRESS_WIDTH-1:0] o_clr_addr
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(SIZE - 1);
    localparam logic                     CLEAR_EN  = (CLEAR_ON_RESET != 0);

    ram_state_e               r_state;
    logic                     r_ready;
    logic                     r_clr_we;
    logic [ADDRESS_WIDTH-1:0] r_clr_addr;

    // State, clear address counter and registered ready/clear-enable outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= {ADDRESS_WIDTH{1'b0}};
            r_ready    <= 1'b0;
            r_clr_we   <= CLEAR_EN;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (!CLEAR_EN || (r_clr_addr == LAST_ADDR)) begin
                        r_state  <= ST_RUN;
                        r_ready  <= 1'b1;
                        r_clr_we <= 1'b0;
                    end else begin
                        r_clr_addr <= r_clr_addr + ADDRESS_WIDTH'(1);
                    end
                end
                ST_RUN: begin
                    r_ready  <= 1'b1;
                    r_clr_we <= 1'b0;
                end
                default: begin
                    r_state  <= ST_CLEAR;
                    r_ready  <= 1'b0;
                    r_clr_we <= CLEAR_EN;
                end
            endcase
        end
    end

    assign o_ready    = r_ready;
    assign o_clr_we   = r_clr_we;
    assign o_clr_addr = r_clr_addr;

endmodule

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte strobes, 1- or 2-cycle read latency,
// selectable read-during-write result and a post-reset hardware clear.
module ram_dp_be
    import ram_pkg::*;
#(
    parameter int    DATA_WIDTH     = 32,
    parameter int    BYTE_WIDTH     = 8,
    parameter int    SIZE           = 1024,
    parameter int    READ_LATENCY   = 1,
    parameter int    RDW_MODE       = 0,
    parameter int    CLEAR_ON_RESET = 1,
    parameter string INIT_FILE      = "",
    localparam int   ADDRESS_WIDTH  = $clog2(SIZE),
    localparam int   NUM_BYTES      = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     ready,
    input  logic                     w_enable,
    input  logic [ADDRESS_WIDTH-1:0] w_address,
    input  logic [NUM_BYTES-1:0]     w_strobe,
    input  logic [DATA_WIDTH-1:0]    w_data,
    input  logic                     r_enable,
    input  logic [ADDRESS_WIDTH-1:0] r_address,
    output logic [DATA_WIDTH-1:0]    r_data,
    output logic                     r_valid
);

    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_chk_width
        $error("ram_dp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_chk_latency
        $error("ram_dp_be: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH > RAM_MAX_DW) begin : g_chk_max
        $error("ram_dp_be: DATA_WIDTH exceeds ram_merge capacity");
    end
    if ((INIT_FILE != "") && (CLEAR_ON_RESET != 0)) begin : g_chk_init
        $warning("ram_dp_be: INIT_FILE is overwritten by the clear pass");
    end

    logic [DATA_WIDTH-1:0]    r_mem [SIZE];
    logic                     w_ready;
    logic                     w_clr_we;
    logic [ADDRESS_WIDTH-1:0] w_clr_addr;
    logic                     w_wr_in_range;
    logic                     w_rd_in_range;
    logic                     w_user_we;
    logic                     w_mem_we;
    logic [ADDRESS_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0]    w_mem_wdata;
    logic                     w_rd_fire;
    logic [DATA_WIDTH-1:0]    w_rd_word;
    logic [DATA_WIDTH-1:0]    w_rd_result;
    logic                     r_p1_valid;
    logic [DATA_WIDTH-1:0]    r_p1_data;
    logic                     r_p2_valid;
    logic [DATA_WIDTH-1:0]    r_p2_data;

    ram_clear_seq #(
        .SIZE           (SIZE),
        .CLEAR_ON_RESET (CLEAR_ON_RESET),
        .ADDRESS_WIDTH  (ADDRESS_WIDTH)
    ) u_clear_seq (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .o_ready    (w_ready),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    assign w_wr_in_range = (32'(w_address) < SIZE);
    assign w_rd_in_range = (32'(r_address) < SIZE);
    assign w_user_we     = w_ready & w_enable & (|w_strobe) & w_wr_in_range;
    assign w_rd_fire     = w_ready & r_enable;

    // Write port mux: the clear sequencer owns the array until ready rises.
    always_comb begin
        w_mem_we    = w_clr_we | w_user_we;
        w_mem_addr  = w_address;
        w_mem_wdata = {DATA_WIDTH{1'b0}};
        if (w_clr_we) begin
            w_mem_addr  = w_clr_addr;
            w_mem_wdata = {DATA_WIDTH{1'b0}};
        end else begin
            w_mem_wdata = DATA_WIDTH'(ram_merge(RAM_MAX_DW'(r_mem[w_address]),
                                                RAM_MAX_DW'(w_data),
                                                RAM_MAX_DW'(w_strobe), BYTE_WIDTH));
        end
    end

    // Read word with out-of-range zeroing and optional same-address write bypass.
    always_comb begin
        w_rd_word   = {DATA_WIDTH{1'b0}};
        w_rd_result = {DATA_WIDTH{1'b0}};
        if (w_rd_in_range) begin
            w_rd_word = r_mem[r_address];
        end else begin
            w_rd_word = {DATA_WIDTH{1'b0}};
        end
        if ((RDW_MODE == RDW_NEW) && w_user_we && (w_address == r_address)) begin
            w_rd_result = DATA_WIDTH'(ram_merge(RAM_MAX_DW'(w_rd_word),
                                                RAM_MAX_DW'(w_data),
                                                RAM_MAX_DW'(w_strobe), BYTE_WIDTH));
        end else begin
            w_rd_result = w_rd_word;
        end
    end

    // Array storage; contents survive reset and are zeroed only by the clear pass.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Read pipeline; data stages only load on a valid so r_data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1_valid <= 1'b0;
            r_p1_data  <= {DATA_WIDTH{1'b0}};
            r_p2_valid <= 1'b0;
            r_p2_data  <= {DATA_WIDTH{1'b0}};
        end else begin
            r_p1_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_p1_data <= w_rd_result;
            end
            r_p2_valid <= r_p1_valid;
            if (r_p1_valid) begin
                r_p2_data <= r_p1_data;
            end
        end
    end

    assign ready   = w_ready;
    assign r_valid = (READ_LATENCY == 2) ? r_p2_valid : r_p1_valid;
    assign r_data  = (READ_LATENCY == 2) ? r_p2_data  : r_p1_data;

endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be: two instances (16 words/latency 1/old-data and
// 12 words/latency 2/new-data) share one stimulus stream and a cycle-level model.
module tb_ram_dp_be;

    logic             clk;
    logic             rst_n;
    logic             w_enable;
    logic [3:0]       w_address;
    logic [3:0]       w_strobe;
    logic [31:0]      w_data;
    logic             r_enable;
    logic [3:0]       r_address;
    logic [1:0]       rdy_s;
    logic [1:0]       vld_s;
    logic [1:0][31:0] rd_s;

    int n_vec = 0;
    int n_err = 0;

    int          sz  [2] = '{16, 12};
    int          lat [2] = '{1, 2};
    int          rdw [2] = '{0, 1};
    logic [31:0] mm  [2][16];
    bit          m_rdy [2];
    int          m_cnt [2];
    bit          m_p1v [2];
    logic [31:0] m_p1d [2];
    bit          m_ov  [2];
    logic [31:0] m_od  [2];
    int          first_rdy [2];

    ram_dp_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .SIZE(16), .READ_LATENCY(1),
                .RDW_MODE(0), .CLEAR_ON_RESET(1), .INIT_FILE("")) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ready(rdy_s[0]),
        .w_enable(w_enable), .w_address(w_address), .w_strobe(w_strobe), .w_data(w_data),
        .r_enable(r_enable), .r_address(r_address), .r_data(rd_s[0]), .r_valid(vld_s[0]));

    ram_dp_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .SIZE(12), .READ_LATENCY(2),
                .RDW_MODE(1), .CLEAR_ON_RESET(1), .INIT_FILE("")) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ready(rdy_s[1]),
        .w_enable(w_enable), .w_address(w_address), .w_strobe(w_strobe), .w_data(w_data),
        .r_enable(r_enable), .r_address(r_address), .r_data(rd_s[1]), .r_valid(vld_s[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  s);
        logic [31:0] res = old_w;
        for (int i = 0; i < 4; i++) if (s[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
        return res;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk("ready",   k, {31'd0, rdy_s[k]}, {31'd0, m_rdy[k]});
            chk("r_valid", k, {31'd0, vld_s[k]}, {31'd0, m_ov[k]});
            chk("r_data",  k, rd_s[k], m_od[k]);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_rdy[k] = 1'b0; m_cnt[k] = 0;
            m_p1v[k] = 1'b0; m_p1d[k] = 32'd0;
            m_ov[k]  = 1'b0; m_od[k]  = 32'd0;
        end
    endtask

    // One rising edge of the reference: read first (pre-write contents), then write/clear.
    task automatic model_edge();
        bit          fire;
        bit          wok;
        logic [31:0] rv;
        if (!rst_n) return;
        for (int k = 0; k < 2; k++) begin
            fire = m_rdy[k] && r_enable;
            wok  = m_rdy[k] && w_enable && (int'(w_address) < sz[k]);
            if (int'(r_address) < sz[k]) begin
                rv = mm[k][r_address];
                if (rdw[k] == 1 && wok && w_address == r_address)
                    rv = lane_merge(rv, w_data, w_strobe);
            end else begin
                rv = 32'd0;
            end
            if (lat[k] == 1) begin
                m_ov[k] = fire;
                if (fire) m_od[k] = rv;
            end else begin
                m_ov[k] = m_p1v[k];
                if (m_p1v[k]) m_od[k] = m_p1d[k];
                m_p1v[k] = fire;
                if (fire) m_p1d[k] = rv;
            end
            if (wok) mm[k][w_address] = lane_merge(mm[k][w_address], w_data, w_strobe);
            if (!m_rdy[k]) begin
                mm[k][m_cnt[k]] = 32'd0;
                m_cnt[k]++;
                if (m_cnt[k] == sz[k]) m_rdy[k] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_idle();
        w_enable = 1'b0; w_address = 4'd0; w_strobe = 4'd0; w_data = 32'd0;
        r_enable = 1'b0; r_address = 4'd0;
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    task automatic run_clear(input bit traffic);
        first_rdy[0] = -1; first_rdy[1] = -1;
        for (int i = 0; i < 20; i++) begin
            set_idle();
            if (traffic && i < 11) begin
                w_enable = 1'b1; w_address = 4'($urandom); w_strobe = 4'hF;
                w_data = $urandom; r_enable = 1'b1; r_address = 4'($urandom);
            end
            tick();
            for (int k = 0; k < 2; k++) if (rdy_s[k] && first_rdy[k] < 0) first_rdy[k] = i + 1;
        end
        for (int k = 0; k < 2; k++) chk("clear_len", k, 32'(first_rdy[k]), 32'(sz[k]));
    endtask

    task automatic sweep_reads();
        for (int a = 0; a < 16; a++) begin
            set_idle(); r_enable = 1'b1; r_address = 4'(a);
            tick();
        end
        set_idle(); tick(); tick();
    endtask

    initial begin
        logic [5:0] vpat0;
        logic [5:0] vpat1;
        rst_n = 1'b0;
        set_idle();
        model_reset();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Clear pass with dropped writes/reads, then every word must read as zero.
        run_clear(1'b1);
        sweep_reads();

        // Byte strobes on address 5.
        set_idle(); w_enable = 1'b1; w_address = 4'd5; w_strobe = 4'hF; w_data = 32'hAABBCCDD;
        tick();
        w_strobe = 4'h5; w_data = 32'h11223344;
        tick();
        set_idle(); r_enable = 1'b1; r_address = 4'd5;
        tick();
        chk("strobe", 0, rd_s[0], 32'hAA22CC44);
        set_idle();
        tick();
        chk("strobe", 1, rd_s[1], 32'hAA22CC44);

        // Three back-to-back reads: valid pattern per latency.
        for (int i = 1; i <= 3; i++) begin
            set_idle(); w_enable = 1'b1; w_address = 4'(i); w_strobe = 4'hF; w_data = 32'h100 + i;
            tick();
        end
        vpat0 = 6'd0; vpat1 = 6'd0;
        for (int t = 0; t < 6; t++) begin
            set_idle();
            if (t < 3) begin r_enable = 1'b1; r_address = 4'(t + 1); end
            tick();
            vpat0[t] = vld_s[0]; vpat1[t] = vld_s[1];
        end
        chk("lat_pattern", 0, {26'd0, vpat0}, 32'h07);
        chk("lat_pattern", 1, {26'd0, vpat1}, 32'h0E);

        // Read-during-write on cleared address 7.
        set_idle(); w_enable = 1'b1; w_address = 4'd7; w_strobe = 4'h3; w_data = 32'hFFFFFFFF;
        r_enable = 1'b1; r_address = 4'd7;
        tick();
        chk("rdw_old", 0, rd_s[0], 32'h00000000);
        set_idle();
        tick();
        chk("rdw_new", 1, rd_s[1], 32'h0000FFFF);

        // Out-of-range address 13 on the 12-word instance.
        set_idle(); w_enable = 1'b1; w_address = 4'd13; w_strobe = 4'hF; w_data = 32'hDEADBEEF;
        tick();
        set_idle(); r_enable = 1'b1; r_address = 4'd13;
        tick();
        set_idle();
        tick();
        chk("oor_valid", 1, {31'd0, vld_s[1]}, 32'd1);
        chk("oor_data",  1, rd_s[1], 32'd0);
        sweep_reads();

        // Randomised traffic with frequent same-address collisions.
        for (int i = 0; i < 300; i++) begin
            w_enable  = 1'($urandom);
            w_address = 4'($urandom);
            w_strobe  = 4'($urandom);
            w_data    = $urandom;
            r_enable  = 1'($urandom);
            r_address = ($urandom_range(0, 3) == 0) ? w_address : 4'($urandom);
            tick();
        end

        // Reset in RUN, then again at clear address 9.
        async_reset();
        for (int i = 0; i < 9; i++) begin set_idle(); tick(); end
        async_reset();
        run_clear(1'b0);
        sweep_reads();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
